// File: rtl/qfa_pkg.sv
// qfa_pkg: shared defaults and controller state encoding for qpi_flash_arbiter.
package qfa_pkg;
  localparam int QFA_ADDR_W    = 24;
  localparam int QFA_INIT_WAIT = 32;
  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} qfa_state_e;
endpackage

// File: rtl/qfa_rr_pick.sv
// qfa_rr_pick: combinational round-robin picker, first set request at or above ptr with wrap.
module qfa_rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [IW-1:0] j;
  always_comb begin
    idx_o = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (req_i[j]) idx_o = j;
    end
  end
  assign any_o = |req_i;
  assign gnt_o = any_o ? N'(1) << idx_o : '0;
endmodule

// File: rtl/qpi_flash_arbiter.sv
// qpi_flash_arbiter: round-robin share of one single-byte QPI flash reader among N requesters.
// Define QFA_LAST_BYTE_CACHE_EN to answer a repeat read of the last fetched address without flash access.
module qpi_flash_arbiter
  import qfa_pkg::*;
#(
  parameter int N         = 2,
  parameter int INIT_WAIT = QFA_INIT_WAIT,
  parameter int ADDR_W    = QFA_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N*ADDR_W-1:0]   req_addr,
  output logic [N-1:0]          gnt,
  output logic [N-1:0]          rsp_valid,
  output logic [7:0]            rsp_data,
  output logic                  busy,
  output logic                  rd_read,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic                  rd_ready,
  input  logic [7:0]            rd_data
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(INIT_WAIT + 1);
  qfa_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] rsp_q, rsp_d;
  logic [N-1:0] pick_gnt;
  logic [IW-1:0] pick_idx;
  logic pick_any;
  logic [ADDR_W-1:0] pick_addr;
  logic hit;
  logic [7:0] hit_data;

  qfa_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req_i(req),
    .ptr_i(ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );

  assign pick_addr = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];

`ifdef QFA_LAST_BYTE_CACHE_EN
  logic cv_q;
  logic [ADDR_W-1:0] ca_q;
  logic [7:0] cd_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cv_q <= 1'b0;
      ca_q <= '0;
      cd_q <= '0;
    end else if (state_q == ST_WAIT && rd_ready) begin
      cv_q <= 1'b1;
      ca_q <= addr_q;
      cd_q <= rd_data;
    end
  end
  assign hit = cv_q && ca_q == pick_addr;
  assign hit_data = cd_q;
`else
  assign hit = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    addr_d = addr_q;
    rsp_d = rsp_q;
    gnt = '0;
    rsp_valid = '0;
    rd_read = 1'b0;
    case (state_q)
      // reader may still be finishing its QPI enable or a read cut short by reset
      ST_INIT: begin
        cnt_d = cnt_q + CW'(1);
        state_d = cnt_q == CW'(INIT_WAIT - 1) ? ST_IDLE : ST_INIT;
      end
      ST_IDLE: if (pick_any) begin
        gnt = pick_gnt;
        idx_d = pick_idx;
        addr_d = pick_addr;
        ptr_d = int'(pick_idx) == N - 1 ? '0 : pick_idx + IW'(1);
        rsp_d = hit ? hit_data : rsp_q;
        state_d = hit ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        rd_read = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: if (rd_ready) begin
        rsp_d = rd_data;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = N'(1) << idx_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q <= '0;
      ptr_q <= '0;
      idx_q <= '0;
      addr_q <= '0;
      rsp_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      addr_q <= addr_d;
      rsp_q <= rsp_d;
    end
  end

  assign rsp_data = rsp_q;
  assign rd_addr = addr_q;
  assign busy = state_q != ST_IDLE;
endmodule

// File: tb/tb_qpi_flash_arbiter.sv
// tb_qpi_flash_arbiter: directed scenarios plus random traffic checked against a transaction-level model.
module tb_qpi_flash_arbiter;
  localparam int N = 2;
  localparam int INIT_WAIT = 32;
  localparam int ADDR_W = 24;
`ifdef QFA_LAST_BYTE_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req;
  logic [N*ADDR_W-1:0] req_addr;
  logic [N-1:0] gnt, rsp_valid;
  logic [7:0] rsp_data, rd_data;
  logic busy, rd_read, rd_ready;
  logic [ADDR_W-1:0] rd_addr;

  int errors = 0;
  int checks = 0;
  int fixed_lat = 14;

  always #5 clk = ~clk;

  qpi_flash_arbiter #(.N(N), .INIT_WAIT(INIT_WAIT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .rd_read(rd_read),
    .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] data_of(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[23:16] ^ 8'hE5;
  endfunction

  function automatic int rr_first(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // flash reader: answers each rd_read with data_of(addr) after a latency
  logic [ADDR_W-1:0] fa;
  int lat;
  initial begin
    rd_ready = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      if (rd_read) begin
        fa = rd_addr;
        lat = fixed_lat > 0 ? fixed_lat : int'($urandom_range(1, 20));
        repeat (lat) @(posedge clk);
        #1 rd_ready = 1'b1;
        rd_data = data_of(fa);
        @(posedge clk);
        #1 rd_ready = 1'b0;
      end
    end
  end

  // reference model: transaction timing derived from grant/ready events
  logic prev_rst = 1'b1;
  int cyc = 0, init_left = 0, ptr = 0, fi;
  bit txn = 0, hit = 0, c_valid = 0;
  int g_idx, g_cyc, rsp_cyc;
  logic [ADDR_W-1:0] g_addr, c_addr;
  logic [7:0] last_rsp = '0;
  logic [N-1:0] eg;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_rst) begin
        chk("rst_gnt", gnt, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rd_read", rd_read, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_busy", busy, 1);
        init_left = INIT_WAIT;
        txn = 0;
        ptr = 0;
        c_valid = 0;
        last_rsp = '0;
      end
      if (init_left > 0) begin
        chk("init_gnt", gnt, 0);
        chk("init_rd_read", rd_read, 0);
        chk("init_busy", busy, 1);
        chk("init_rsp_valid", rsp_valid, 0);
        init_left--;
      end else if (!txn) begin
        fi = rr_first(req, ptr);
        eg = fi < 0 ? '0 : N'(1) << fi;
        chk("idle_gnt", gnt, eg);
        chk("idle_busy", busy, 0);
        chk("idle_rd_read", rd_read, 0);
        chk("idle_rsp_valid", rsp_valid, 0);
        if (fi >= 0) begin
          txn = 1;
          g_idx = fi;
          g_cyc = cyc;
          g_addr = req_addr[fi*ADDR_W +: ADDR_W];
          ptr = (fi + 1) % N;
          hit = CACHE_EN && c_valid && c_addr == g_addr;
          rsp_cyc = hit ? cyc + 1 : -1;
        end
      end else begin
        chk("txn_busy", busy, 1);
        chk("txn_gnt", gnt, 0);
        chk("rd_read", rd_read, (!hit && cyc == g_cyc + 1) ? 1 : 0);
        if (!hit && cyc == g_cyc + 1) chk("rd_addr", rd_addr, g_addr);
        if (!hit && rsp_cyc < 0 && cyc >= g_cyc + 2 && rd_ready) begin
          rsp_cyc = cyc + 1;
          c_valid = 1;
          c_addr = g_addr;
        end
        if (cyc == rsp_cyc) begin
          chk("rsp_valid", rsp_valid, 1 << g_idx);
          last_rsp = data_of(g_addr);
          txn = 0;
        end else begin
          chk("rsp_valid_quiet", rsp_valid, 0);
        end
        if (txn && cyc - g_cyc > 200) begin
          chk("txn_timeout", cyc - g_cyc, 200);
          txn = 0;
        end
      end
      chk("rsp_data", rsp_data, last_rsp);
      prev_rst = rst;
    end
  end

  task automatic wait_gnt(input int i, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (gnt[i] !== 1'b1 && n < 300);
  endtask

  task automatic wait_rsp(input int i, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (rsp_valid[i] !== 1'b1 && n < 300);
  endtask

  int n, cnt, exp_idx;
  logic [N-1:0] g;
  initial begin
    rst = 1'b1;
    req = '0;
    req_addr = '0;
    req[0] = 1'b1;
    req_addr[0 +: ADDR_W] = 24'h400000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_gnt(0, n);
    chk("t1_gnt_lat", n, INIT_WAIT + 1);
    @(negedge clk);
    chk("t1_rd_read", rd_read, 1);
    chk("t1_rd_addr", rd_addr, 24'h400000);
    @(posedge clk);
    #1 req[0] = 1'b0;
    wait_rsp(0, n);
    chk("t2_rsp_lat", n, 15);
    chk("t2_rsp_data", rsp_data, 8'hA5);
    @(negedge clk);
    chk("t2_busy_low", busy, 0);

    @(posedge clk);
    #1 req_addr = {24'h000200, 24'h000100};
    req = 2'b11;
    exp_idx = 1;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (gnt == '0 && n < 300);
      chk("t3_alt", gnt, N'(1) << exp_idx);
      exp_idx = 1 - exp_idx;
    end
    @(posedge clk);
    #1 req = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 300);
    chk("t3_idle", busy, 0);

    @(posedge clk);
    #1 req[0] = 1'b1;
    req_addr[0 +: ADDR_W] = 24'h123456;
    wait_gnt(0, n);
    chk("t4_gnt", gnt, 1);
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(negedge clk);
    chk("t4_rd_read", rd_read, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) cnt++;
    end
    chk("t4_no_rsp", cnt, 0);

    @(posedge clk);
    #1 req[1] = 1'b1;
    req_addr[ADDR_W +: ADDR_W] = 24'h400777;
    wait_gnt(1, n);
    chk("t5_gnt", gnt, 2);
    @(posedge clk);
    #1 req[1] = 1'b0;
    wait_rsp(1, n);
    chk("t5_rsp_valid", rsp_valid, 2);
    chk("t5_rsp_data", rsp_data, data_of(24'h400777));

`ifdef QFA_LAST_BYTE_CACHE_EN
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1 req[0] = 1'b1;
      req_addr[0 +: ADDR_W] = 24'h400005;
      wait_gnt(0, n);
      @(posedge clk);
      #1 req[0] = 1'b0;
      if (k == 0) begin
        wait_rsp(0, n);
        chk("t6_first_data", rsp_data, data_of(24'h400005));
        @(negedge clk);
      end else begin
        @(negedge clk);
        chk("t6_hit_rsp_valid", rsp_valid, 1);
        chk("t6_hit_no_rd", rd_read, 0);
        chk("t6_hit_data", rsp_data, data_of(24'h400005));
      end
    end
`endif

    fixed_lat = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (req[i] && g[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if (req[i]) begin
          if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(32'h400000 + $urandom_range(0, 3));
          req[i] = 1'b1;
        end
      end
    end
    req = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 300);
    chk("drain_idle", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
